gate_select_sweeper: RTL and testbench
======================================

Name: gate_select_sweeper

Overview:
- Self-checking stimulus driver and response checker for the 3-bit-select two-input gate selector (sel 000..111 → NAND, AND, OR, NOR, XOR, XNOR, NOT a, NOT a).
- Drives a, b and sel into the selector and samples its out on the return path.
- Sweeps all 32 {sel,a,b} combinations and compares each response against an internal truth table.
- Reports pass/fail, error count and first failing vector; used on-board and in simulation as the selector's counterpart.

Parameters:
- SETTLE_CYCLES, 2, number of cycles each vector is held before sampling; legal range 1..15.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  begin sweep; sampled only in IDLE.
- a  output  1  operand a to selector.
- b  output  1  operand b to selector.
- sel  output  3  function select to selector.
- dut_out  input  1  selector result.
- busy  output  1  high in DRIVE/SAMPLE.
- done  output  1  one-cycle pulse at sweep end.
- pass  output  1  sweep result, valid from done until next start.
- err_cnt  output  6  mismatch count, 0..32.
- fail_valid  output  1  at least one mismatch captured.
- fail_vec  output  5  {sel,a,b} of first mismatch.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high, ports clk/rst.
- Reset values: a=0, b=0, sel=0, busy=0, done=0, pass=0, err_cnt=0, fail_valid=0, fail_vec=0, state=IDLE, idx=0, settle counter=0.
- Vector index: idx[4:0], with sel=idx[4:2], a=idx[1], b=idx[0]. Sweep order is 0..31 ascending.
- Expected value by sel: 000 ~(a&b), 001 a&b, 010 a|b, 011 ~(a|b), 100 a^b, 101 ~(a^b), 110 ~a, 111 ~a.
- IDLE: a/b/sel=0, busy=0.
  - start=1 at an edge → DRIVE with idx=0.
  - Same edge clears err_cnt, fail_valid, fail_vec and pass.
- DRIVE: a/b/sel driven from idx, registered outputs. Stays exactly SETTLE_CYCLES cycles (settle counter counts 0..SETTLE_CYCLES-1), then → SAMPLE.
- SAMPLE: one cycle, vector still driven. On the edge leaving SAMPLE:
  - If dut_out != expected: err_cnt += 1.
  - If dut_out != expected and fail_valid was 0: fail_vec = idx and fail_valid = 1. Only the first mismatch is captured.
  - If idx==31: → DONE. Otherwise idx += 1, → DRIVE.
- DONE: one cycle.
  - done=1, busy=0, a/b/sel return to 0.
  - pass = (err_cnt==0), using the final count including the last sample.
  - → IDLE.
- Timing: start sampled at edge k → vector 0 visible after edge k. done is high during the cycle after edge k+32*(SETTLE_CYCLES+1). With default SETTLE_CYCLES=2, done follows edge k+96.
- Held results: pass, err_cnt, fail_valid and fail_vec hold after DONE until the next accepted start.
- start while busy or in DONE: ignored, no restart.
- start held high continuously: a new sweep is accepted on the first IDLE edge after DONE.
- err_cnt width: 6 bits so 32 cannot wrap.
- rst mid-sweep: all state and outputs return to reset values at that edge; no done pulse; next start runs a full sweep from idx 0.

Test Plan:
- Correct selector model on dut_out, SETTLE_CYCLES=2 → busy for 96 cycles, done pulse 1 cycle, pass=1, err_cnt=0, fail_valid=0.
- dut_out stuck at 0 → err_cnt=16, fail_valid=1, fail_vec=5'b00000 (NAND, a=0, b=0), pass=0.
- dut_out stuck at 1 → err_cnt=16, fail_vec=5'b00011 (NAND, a=1, b=1), pass=0.
- Faulty model returning ~b for sel=111 → err_cnt=2, fail_vec=5'b11101, pass=0.
- rst asserted while idx=10, then start, with the correct model:
  - After rst: busy=0, sel/a/b=0, no done pulse.
  - New sweep runs full length from idx 0 with pass=1.
- start pulsed again mid-sweep (ignored, sweep length unchanged); SETTLE_CYCLES=1 → done follows start edge +64.

Source files
------------

// File: rtl/gate_select_sweeper_if.sv
// Selector-side bus: stimulus operands/select out, gate result back in.
interface gate_select_sweeper_if;
  logic       a;
  logic       b;
  logic [2:0] sel;
  logic       dut_out;

  // Sweeper drives the vector and reads the result.
  modport master (
    output a,
    output b,
    output sel,
    input  dut_out
  );

  // Gate selector under test.
  modport slave (
    input  a,
    input  b,
    input  sel,
    output dut_out
  );
endinterface

// File: rtl/gate_select_sweeper.sv
// Stimulus driver and response checker for the 3-bit-select two-input gate selector.
// Walks all 32 {sel,a,b} vectors in ascending order, holds each for SETTLE_CYCLES
// cycles, samples the selector result for one cycle and compares it with a
// built-in truth table. Reports pass, mismatch count and the first failing vector.
module gate_select_sweeper #(
  parameter int unsigned SETTLE_CYCLES = 2  // legal range 1..15
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  gate_select_sweeper_if.master        sel_if,
  output logic                         busy,
  output logic                         done,
  output logic                         pass,
  output logic [5:0]                   err_cnt,
  output logic                         fail_valid,
  output logic [4:0]                   fail_vec
);

  typedef enum logic [1:0] {
    StIdle,
    StDrive,
    StSample,
    StDone
  } state_e;

  localparam logic [3:0] LastCnt = 4'(SETTLE_CYCLES - 1);

  state_e      r_state;
  logic [4:0]  r_idx;
  logic [3:0]  r_cnt;
  logic        r_a;
  logic        r_b;
  logic [2:0]  r_sel;
  logic        r_busy;
  logic        r_done;
  logic        r_pass;
  logic [5:0]  r_err_cnt;
  logic        r_fail_valid;
  logic [4:0]  r_fail_vec;

  logic        w_exp;
  logic        w_mismatch;
  logic [4:0]  w_idx_next;
  logic [5:0]  w_err_next;

  // Reference truth table for the vector currently driven.
  always_comb begin
    w_exp = 1'b0;
    unique case (r_idx[4:2])
      3'b000: w_exp = ~(r_idx[1] & r_idx[0]);
      3'b001: w_exp = r_idx[1] & r_idx[0];
      3'b010: w_exp = r_idx[1] | r_idx[0];
      3'b011: w_exp = ~(r_idx[1] | r_idx[0]);
      3'b100: w_exp = r_idx[1] ^ r_idx[0];
      3'b101: w_exp = ~(r_idx[1] ^ r_idx[0]);
      3'b110: w_exp = ~r_idx[1];
      3'b111: w_exp = ~r_idx[1];
      default: w_exp = 1'b0;
    endcase
  end

  assign w_mismatch = (sel_if.dut_out != w_exp);
  assign w_idx_next = r_idx + 5'd1;
  // Count including the sample being taken this cycle, so pass sees the final total.
  assign w_err_next = r_err_cnt + {5'd0, w_mismatch};

  // Sweep sequencer with registered vector and status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= StIdle;
      r_idx        <= 5'd0;
      r_cnt        <= 4'd0;
      r_a          <= 1'b0;
      r_b          <= 1'b0;
      r_sel        <= 3'd0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_pass       <= 1'b0;
      r_err_cnt    <= 6'd0;
      r_fail_valid <= 1'b0;
      r_fail_vec   <= 5'd0;
    end else begin
      case (r_state)
        StIdle: begin
          r_done <= 1'b0;
          if (start) begin
            r_state      <= StDrive;
            r_idx        <= 5'd0;
            r_cnt        <= 4'd0;
            r_a          <= 1'b0;
            r_b          <= 1'b0;
            r_sel        <= 3'd0;
            r_busy       <= 1'b1;
            r_pass       <= 1'b0;
            r_err_cnt    <= 6'd0;
            r_fail_valid <= 1'b0;
            r_fail_vec   <= 5'd0;
          end
        end
        StDrive: begin
          if (r_cnt == LastCnt) begin
            r_state <= StSample;
            r_cnt   <= 4'd0;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        StSample: begin
          r_err_cnt <= w_err_next;
          // Only the first mismatch of a sweep is captured.
          if (w_mismatch && !r_fail_valid) begin
            r_fail_valid <= 1'b1;
            r_fail_vec   <= r_idx;
          end
          if (r_idx == 5'd31) begin
            r_state <= StDone;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_a     <= 1'b0;
            r_b     <= 1'b0;
            r_sel   <= 3'd0;
            r_pass  <= (w_err_next == 6'd0);
          end else begin
            r_state <= StDrive;
            r_idx   <= w_idx_next;
            r_sel   <= w_idx_next[4:2];
            r_a     <= w_idx_next[1];
            r_b     <= w_idx_next[0];
          end
        end
        StDone: begin
          // start is ignored here; a held start is taken on the next IDLE edge.
          r_done  <= 1'b0;
          r_state <= StIdle;
        end
        default: begin
          r_state <= StIdle;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign sel_if.a   = r_a;
  assign sel_if.b   = r_b;
  assign sel_if.sel = r_sel;
  assign busy       = r_busy;
  assign done       = r_done;
  assign pass       = r_pass;
  assign err_cnt    = r_err_cnt;
  assign fail_valid = r_fail_valid;
  assign fail_vec   = r_fail_vec;

endmodule

// File: tb/tb_gate_select_sweeper.sv
// Bench for gate_select_sweeper: two instances (settle 2 and settle 1), each driving
// a behavioural gate selector with selectable fault. Stimulus pushes expected sweep
// results into per-instance queues; monitors pop and compare on every done pulse.
module tb_gate_select_sweeper;

  localparam int unsigned S1 = 2;
  localparam int unsigned S2 = 1;

  typedef struct {
    logic        pass;
    logic [5:0]  err;
    logic        fv;
    logic [4:0]  vec;
    int unsigned done_cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start1;
  logic        start2;
  int unsigned cyc = 0;
  int          n_checks = 0;
  int          n_err = 0;
  int          mode1 = 0;
  int          mode2 = 0;
  exp_t        q1[$];
  exp_t        q2[$];

  logic        busy1, done1, pass1, fv1;
  logic [5:0]  err1;
  logic [4:0]  vec1;
  logic        busy2, done2, pass2, fv2;
  logic [5:0]  err2;
  logic [4:0]  vec2;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  gate_select_sweeper_if u_if1 ();
  gate_select_sweeper_if u_if2 ();

  // Behavioural selector: 0 correct, 1 stuck-0, 2 stuck-1, 3 ~b on sel 111.
  function automatic logic sel_model(input int mode, input logic [2:0] s,
                                     input logic a, input logic b);
    logic r;
    case (s)
      3'b000:  r = ~(a & b);
      3'b001:  r = a & b;
      3'b010:  r = a | b;
      3'b011:  r = ~(a | b);
      3'b100:  r = a ^ b;
      3'b101:  r = ~(a ^ b);
      3'b110:  r = ~a;
      default: r = (mode == 3) ? ~b : ~a;
    endcase
    if (mode == 1) r = 1'b0;
    if (mode == 2) r = 1'b1;
    return r;
  endfunction

  assign u_if1.dut_out = sel_model(mode1, u_if1.sel, u_if1.a, u_if1.b);
  assign u_if2.dut_out = sel_model(mode2, u_if2.sel, u_if2.a, u_if2.b);

  gate_select_sweeper #(.SETTLE_CYCLES(S1)) u_dut1 (
    .clk        (clk),
    .rst        (rst),
    .start      (start1),
    .sel_if     (u_if1),
    .busy       (busy1),
    .done       (done1),
    .pass       (pass1),
    .err_cnt    (err1),
    .fail_valid (fv1),
    .fail_vec   (vec1)
  );

  gate_select_sweeper #(.SETTLE_CYCLES(S2)) u_dut2 (
    .clk        (clk),
    .rst        (rst),
    .start      (start2),
    .sel_if     (u_if2),
    .busy       (busy2),
    .done       (done2),
    .pass       (pass2),
    .err_cnt    (err2),
    .fail_valid (fv2),
    .fail_vec   (vec2)
  );

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor for instance 1.
  initial begin
    int   busy_cnt = 0;
    logic done_prev = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        busy_cnt  = 0;
        done_prev = 1'b0;
      end else begin
        if (busy1) busy_cnt++;
        if (done1) begin
          if (q1.size() == 0) begin
            check("dut1_unexpected_done", 1, 0);
          end else begin
            e = q1.pop_front();
            check("dut1_pass", int'(pass1), int'(e.pass));
            check("dut1_err_cnt", int'(err1), int'(e.err));
            check("dut1_fail_valid", int'(fv1), int'(e.fv));
            check("dut1_fail_vec", int'(vec1), int'(e.vec));
            check("dut1_done_cycle", int'(cyc), int'(e.done_cyc));
            check("dut1_busy_cycles", busy_cnt, 96);
            check("dut1_busy_in_done", int'(busy1), 0);
          end
          check("dut1_done_width", int'(done_prev), 0);
          busy_cnt = 0;
        end
        done_prev = done1;
      end
    end
  end

  // Monitor for instance 2.
  initial begin
    int   busy_cnt = 0;
    logic done_prev = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        busy_cnt  = 0;
        done_prev = 1'b0;
      end else begin
        if (busy2) busy_cnt++;
        if (done2) begin
          if (q2.size() == 0) begin
            check("dut2_unexpected_done", 1, 0);
          end else begin
            e = q2.pop_front();
            check("dut2_pass", int'(pass2), int'(e.pass));
            check("dut2_err_cnt", int'(err2), int'(e.err));
            check("dut2_fail_valid", int'(fv2), int'(e.fv));
            check("dut2_fail_vec", int'(vec2), int'(e.vec));
            check("dut2_done_cycle", int'(cyc), int'(e.done_cyc));
            check("dut2_busy_cycles", busy_cnt, 64);
          end
          check("dut2_done_width", int'(done_prev), 0);
          busy_cnt = 0;
        end
        done_prev = done2;
      end
    end
  end

  // Advance to just after the next rising edge.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_done(input int which, input int max);
    int   i;
    logic seen;
    seen = 1'b0;
    for (i = 0; i < max && !seen; i++) begin
      tick(1);
      seen = (which == 1) ? done1 : done2;
    end
    if (!seen) check($sformatf("dut%0d_done_timeout", which), 0, 1);
  endtask

  // Pulse start for one edge on the chosen instance and queue the expected outcome.
  task automatic run_sweep(input int which, input logic p, input logic [5:0] err,
                           input logic fv, input logic [4:0] vec);
    exp_t e;
    e.pass = p;
    e.err  = err;
    e.fv   = fv;
    e.vec  = vec;
    e.done_cyc = cyc + 1 + ((which == 1) ? 96 : 64);
    if (which == 1) begin
      q1.push_back(e);
      start1 = 1'b1;
    end else begin
      q2.push_back(e);
      start2 = 1'b1;
    end
    tick(1);
    start1 = 1'b0;
    start2 = 1'b0;
  endtask

  initial begin
    exp_t e;
    int   i;
    rst    = 1'b1;
    start1 = 1'b0;
    start2 = 1'b0;
    tick(3);
    rst = 1'b0;
    tick(1);

    // Reset state.
    check("rst_busy", int'(busy1), 0);
    check("rst_done", int'(done1), 0);
    check("rst_pass", int'(pass1), 0);
    check("rst_err_cnt", int'(err1), 0);
    check("rst_fail_valid", int'(fv1), 0);
    check("rst_fail_vec", int'(vec1), 0);
    check("rst_vector", int'({u_if1.sel, u_if1.a, u_if1.b}), 0);

    // Correct selector.
    mode1 = 0;
    run_sweep(1, 1'b1, 6'd0, 1'b0, 5'd0);
    check("start_vector0_busy", int'(busy1), 1);
    wait_done(1, 200);
    tick(3);
    check("held_pass", int'(pass1), 1);

    // Stuck at 0: every expected-1 vector fails, first is NAND(0,0).
    mode1 = 1;
    run_sweep(1, 1'b0, 6'd16, 1'b1, 5'b00000);
    wait_done(1, 200);
    tick(3);
    check("held_err_cnt", int'(err1), 16);

    // Stuck at 1: first expected-0 vector is NAND(1,1).
    mode1 = 2;
    run_sweep(1, 1'b0, 6'd16, 1'b1, 5'b00011);
    wait_done(1, 200);
    tick(3);

    // ~b on sel 111 differs from ~a at idx 29 and 30.
    mode1 = 3;
    run_sweep(1, 1'b0, 6'd2, 1'b1, 5'b11101);
    wait_done(1, 200);
    tick(3);

    // Reset while vector 10 is driven.
    mode1 = 0;
    run_sweep(1, 1'b1, 6'd0, 1'b0, 5'd0);
    for (i = 0; i < 200 && {u_if1.sel, u_if1.a, u_if1.b} != 5'd10; i++) tick(1);
    check("reached_idx10", int'({u_if1.sel, u_if1.a, u_if1.b}), 10);
    e = q1.pop_back();
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check("midrst_busy", int'(busy1), 0);
    check("midrst_vector", int'({u_if1.sel, u_if1.a, u_if1.b}), 0);
    check("midrst_done", int'(done1), 0);
    check("midrst_err_cnt", int'(err1), 0);
    tick(110);
    run_sweep(1, 1'b1, 6'd0, 1'b0, 5'd0);
    wait_done(1, 200);
    tick(3);

    // start held high: back-to-back sweep taken on the first IDLE edge after DONE.
    e.pass = 1'b1; e.err = 6'd0; e.fv = 1'b0; e.vec = 5'd0;
    e.done_cyc = cyc + 1 + 96;
    q1.push_back(e);
    e.done_cyc = cyc + 1 + 98 + 96;
    q1.push_back(e);
    start1 = 1'b1;
    wait_done(1, 200);
    tick(2);
    start1 = 1'b0;
    check("held_start_restart_busy", int'(busy1), 1);
    wait_done(1, 200);
    tick(3);

    // Settle 1 instance: start pulsed mid-sweep and during DONE is ignored.
    mode2 = 0;
    run_sweep(2, 1'b1, 6'd0, 1'b0, 5'd0);
    tick(20);
    start2 = 1'b1;
    tick(1);
    start2 = 1'b0;
    wait_done(2, 200);
    start2 = 1'b1;
    tick(1);
    start2 = 1'b0;
    tick(1);
    check("dut2_start_in_done_busy", int'(busy2), 0);
    mode2 = 1;
    run_sweep(2, 1'b0, 6'd16, 1'b1, 5'b00000);
    wait_done(2, 200);
    tick(10);

    check("dut1_queue_drained", q1.size(), 0);
    check("dut2_queue_drained", q2.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
